mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multicycle control FSM for the MIPS CPU datapath instantiated under `main`. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. From the opcode of the instruction register it drives every datapath mux select and write enable. It waits on a memory-ready handshake and can optionally abort a stalled memory access after a timeout.

## Interface
- `MEM_TIMEOUT`, default 0: maximum cycles to wait for `MemReady` in a memory state. 0 disables the timeout.
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Opcode`  in  6  instruction bits [31:26] from the instruction register; sampled in DECODE.
- `Zero`  in  1  ALU zero flag; consumed by the datapath together with `PCWriteCond`.
- `MemReady`  in  1  memory has completed the current read or write this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1 each  datapath controls.
- `ALUSrcB`  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- `ALUOp`  out  2  00=add, 01=sub, 10=funct-decoded.
- `PCSource`  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- `Retire`  out  1  high during the final cycle of every completed instruction.
- `IllegalOp`  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- `MemTimeout`  out  1  one-cycle pulse when a memory wait is aborted.
- `State`  out  4  current state encoding, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Outputs are Moore-decoded from `State`, except the `MemReady` gating noted below. Any control not listed for a state is 0.
- **FETCH:** MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = MemReady.
  - Goes to DECODE when MemReady=1; otherwise holds.
- **DECODE:** ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target).
  - lw/sw→MEMADR, R-type→EXEC, beq→BEQ, addi→ADDIEX, j→JUMP.
  - Any other opcode: IllegalOp=1, Retire=0, next state FETCH.
- **MEMADR:** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- **MEMRD:** MemRead=1, IorD=1. Holds until MemReady=1, then goes to MEMWB.
- **MEMWB:** RegDst=0, MemtoReg=1, RegWrite=1, Retire=1. Next state FETCH.
- **MEMWR:** MemWrite=1, IorD=1, held for the whole wait. On MemReady=1: Retire=1, next state FETCH.
- **EXEC:** ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state RTYPEWB.
- **RTYPEWB:** RegDst=1, MemtoReg=0, RegWrite=1, Retire=1. Next state FETCH.
- **BEQ:** ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, Retire=1. Next state FETCH.
- **ADDIEX:** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
- **ADDIWB:** RegDst=0, MemtoReg=0, RegWrite=1, Retire=1. Next state FETCH.
- **JUMP:** PCWrite=1, PCSource=10, Retire=1. Next state FETCH.
- **Timeout** (only when MEM_TIMEOUT>0):
  - A wait counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle MemReady=0 in those states.
  - When the counter equals MEM_TIMEOUT with MemReady still 0: MemTimeout=1 that cycle, next state FETCH.
  - No IRWrite, PCWrite, RegWrite or Retire is issued for the aborted access.
  - A timed-out FETCH re-fetches from the unchanged PC.

## Timing
- Reset dominates every other input. While `Reset`=1 all enables and pulses are forced to 0, and the state register loads FETCH on the next edge.
- After release, the first cycle is FETCH.
- Reset asserted mid-instruction abandons it; no partial writeback occurs after the reset edge.
- Cycles per instruction with MemReady tied to 1:
  - R-type 4, lw 5, sw 4, addi 4, beq 3, j 3, illegal 2.
  - Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- MemReady=1 in the first cycle of a memory state completes the access with zero wait.
- `MemReady` is ignored in all states other than FETCH, MEMRD and MEMWR.
- If MemReady=1 arrives in the same cycle the counter reaches MEM_TIMEOUT, the access completes normally and MemTimeout stays 0.
- The wait counter is wide enough for MEM_TIMEOUT and never wraps; it saturates.

## Test plan
- **Reset:** assert Reset for 3 cycles mid-EXEC, then release → State=0 on the first cycle after release; RegWrite never asserts during reset.
- **Instruction mix:** MemReady=1, run Opcode sequence lw, sw, R-type, addi, beq, j → Retire spacing 5, 4, 4, 4, 3, 3 cycles; State traces match the transitions above.
- **Memory waits:** lw with MemReady low 2 cycles in FETCH and 3 in MEMRD → Retire on cycle 10 after FETCH entry; MemRead held through both waits.
- **Illegal opcode:** Opcode=111111 → IllegalOp=1 in cycle 2, State=0 in cycle 3, no Retire.
- **Timeout:** MEM_TIMEOUT=4, sw with MemReady stuck low → MemWrite high for 4 cycles of MEMWR, MemTimeout pulses once, returns to FETCH, no Retire.
- **Timeout boundary:** MEM_TIMEOUT=4 with MemReady rising on the 4th wait cycle → normal completion, MemTimeout=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Multicycle control FSM for the MIPS datapath. One instruction at a time is
// sequenced through fetch, decode, execute, memory and writeback. Every mux
// select and write enable is Moore-decoded from the current state. The only
// exceptions are the memory states, where the MemReady handshake gates the
// enables. An optional timeout aborts a memory access that stalls too long.
//
// Parameters
//   MEM_TIMEOUT  wait cycles allowed per memory access (0 = never abort)
//
// Ports
//   Clock, Reset        clock and synchronous active-high reset
//   Opcode[5:0]         IR[31:26], decoded in DECODE
//   Zero                ALU zero flag (used by the datapath with PCWriteCond)
//   MemReady            memory finished the current access this cycle
//   PCWrite .. ALUSrcA  single-bit datapath enables/selects
//   ALUSrcB[1:0]        00=B, 01=4, 10=sext imm, 11=sext imm<<2
//   ALUOp[1:0]          00=add, 01=sub, 10=funct
//   PCSource[1:0]       00=ALU, 01=ALUOut, 10=jump target
//   Retire              last cycle of a completed instruction
//   IllegalOp           unsupported opcode seen in DECODE
//   MemTimeout          memory wait aborted this cycle
//   State[3:0]          current state encoding (debug)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Retire,
  output logic       IllegalOp,
  output logic       MemTimeout,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam bit TO_EN = (MEM_TIMEOUT > 0);
  localparam int CNT_W = TO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
  // The counter holds the number of wait cycles already spent. The access is
  // aborted in the MEM_TIMEOUT-th consecutive wait cycle, i.e. when the count
  // of earlier waits is MEM_TIMEOUT-1 and MemReady is still low.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? MEM_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TO_EN ? MEM_TIMEOUT : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_mem;
  logic             timeout_hit;

  // The zero flag is consumed by the datapath, not by this controller.
  logic unused_zero;
  assign unused_zero = Zero;

  assign State = state_q;

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    Retire      = 1'b0;
    IllegalOp   = 1'b0;
    MemTimeout  = 1'b0;
    state_d     = state_q;

    in_mem      = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout_hit = TO_EN && in_mem && !MemReady && (cnt_q == CNT_LAST);

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (timeout_hit) begin
          // PC is not advanced, so the re-fetch reads the same address.
          MemTimeout = 1'b1;
          state_d    = S_FETCH;
        end else if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively while decoding.
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            IllegalOp = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (timeout_hit) begin
          MemTimeout = 1'b1;
          state_d    = S_FETCH;
        end else if (MemReady) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        Retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (timeout_hit) begin
          MemTimeout = 1'b1;
          state_d    = S_FETCH;
        end else if (MemReady) begin
          Retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        Retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        Retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        Retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        Retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Wait counter restarts on every state entry, including the FETCH->FETCH
    // re-fetch after an abort, and saturates instead of wrapping.
    if ((state_d != state_q) || timeout_hit) begin
      cnt_d = '0;
    end else if (in_mem && !MemReady && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    // Reset overrides everything: no enable or pulse may leak out.
    if (Reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      Retire      = 1'b0;
      IllegalOp   = 1'b0;
      MemTimeout  = 1'b0;
      state_d     = S_FETCH;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for mips_multicycle_ctrl. The stimulus process plays whole
// instructions (opcode plus a per-phase MemReady wait count). From the
// instruction-level rules it derives the expected control word of every
// cycle and queues it. A separate monitor pops one entry per cycle and
// compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

  localparam int T = 4;

  // Phase numbers are the architected State encodings.
  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5,
                 EX = 6, RWB = 7, BQ = 8, AEX = 9, AWB = 10, JP = 11;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

  logic       Clock;
  logic       Reset;
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegWrite, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       Retire, IllegalOp, MemTimeout;
  logic [3:0] State;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .Retire(Retire), .IllegalOp(IllegalOp),
    .MemTimeout(MemTimeout), .State(State)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, rgw, rdst, asa;
    logic [1:0] asb, aop, pcs;
    logic       ret, ill, mto;
    logic [3:0] st;
  } ctl_t;

  typedef struct {
    ctl_t c;
    bit   chk_st;
    int   id;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;

  // Expected control word for one cycle in a given phase.
  function automatic ctl_t model(int ph, bit rdy, bit to, bit ill);
    ctl_t c;
    c    = '0;
    c.st = 4'(ph);
    case (ph)
      F:   begin c.mrd = 1; c.asb = 2'b01; c.irw = rdy && !to; c.pcw = rdy && !to; c.mto = to; end
      D:   begin c.asb = 2'b11; c.ill = ill; end
      MA:  begin c.asa = 1; c.asb = 2'b10; end
      MR:  begin c.mrd = 1; c.iord = 1; c.mto = to; end
      MWB: begin c.m2r = 1; c.rgw = 1; c.ret = 1; end
      MW:  begin c.mwr = 1; c.iord = 1; c.ret = rdy && !to; c.mto = to; end
      EX:  begin c.asa = 1; c.asb = 2'b00; c.aop = 2'b10; end
      RWB: begin c.rdst = 1; c.rgw = 1; c.ret = 1; end
      BQ:  begin c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; c.ret = 1; end
      AEX: begin c.asa = 1; c.asb = 2'b10; end
      AWB: begin c.rgw = 1; c.ret = 1; end
      JP:  begin c.pcw = 1; c.pcs = 2'b10; c.ret = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
  endfunction

  // One clock cycle of stimulus plus its expectation.
  task automatic cyc(int ph, bit rdy, bit to, bit ill, logic [5:0] op);
    exp_t e;
    @(posedge Clock);
    #1;
    Reset    = 1'b0;
    Opcode   = op;
    MemReady = rdy;
    Zero     = 1'($urandom);
    e.c      = model(ph, rdy, to, ill);
    e.chk_st = 1'b1;
    e.id     = ncyc;
    q.push_back(e);
    ncyc++;
  endtask

  // A memory phase lasting w wait cycles before MemReady, or aborted
  // in the T-th wait cycle if w >= T.
  task automatic mem_phase(int ph, int w, logic [5:0] op, output bit timed);
    timed = 1'b0;
    for (int i = 0; i <= w; i++) begin
      if (i == w) begin
        cyc(ph, 1'b1, 1'b0, 1'b0, op);
        return;
      end
      if (i == T - 1) begin
        cyc(ph, 1'b0, 1'b1, 1'b0, op);
        timed = 1'b1;
        return;
      end
      cyc(ph, 1'b0, 1'b0, 1'b0, op);
    end
  endtask

  task automatic do_reset(int n, bit known, int cur);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
      Reset    = 1'b1;
      MemReady = 1'($urandom);
      Opcode   = 6'($urandom);
      e.c      = '0;
      e.c.st   = (i == 0) ? 4'(cur) : 4'd0;
      e.chk_st = (i == 0) ? known : 1'b1;
      e.id     = ncyc;
      q.push_back(e);
      ncyc++;
    end
  endtask

  task automatic do_instr(int kind, int wf, int wm, logic [5:0] ill_op);
    logic [5:0] op;
    bit         timed;
    case (kind)
      K_R:    op = 6'b000000;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_ADDI: op = 6'b001000;
      K_J:    op = 6'b000010;
      default: op = ill_op;
    endcase
    mem_phase(F, wf, op, timed);
    while (timed) mem_phase(F, $urandom_range(0, 2), op, timed);
    cyc(D, 1'($urandom), 1'b0, kind == K_ILL, op);
    case (kind)
      K_R:    begin cyc(EX, 1'($urandom), 0, 0, op); cyc(RWB, 1'($urandom), 0, 0, op); end
      K_LW:   begin
                cyc(MA, 1'($urandom), 0, 0, op);
                mem_phase(MR, wm, op, timed);
                if (!timed) cyc(MWB, 1'($urandom), 0, 0, op);
              end
      K_SW:   begin cyc(MA, 1'($urandom), 0, 0, op); mem_phase(MW, wm, op, timed); end
      K_BEQ:  cyc(BQ, 1'($urandom), 0, 0, op);
      K_ADDI: begin cyc(AEX, 1'($urandom), 0, 0, op); cyc(AWB, 1'($urandom), 0, 0, op); end
      K_J:    cyc(JP, 1'($urandom), 0, 0, op);
      default: ;
    endcase
  endtask

  // Monitor: one expected control word per cycle.
  initial begin
    exp_t e;
    ctl_t act, mask;
    forever begin
      @(negedge Clock);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               Retire, IllegalOp, MemTimeout, State};
        mask = '1;
        if (!e.chk_st) mask.st = 4'd0;
        total++;
        if ((act & mask) !== (e.c & mask)) begin
          bad++;
          $display("FAIL ctl cycle %0d: got %b required %b (state got %0d required %0d)",
                   e.id, act, e.c, act.st, e.c.st);
        end
      end
    end
  end

  initial begin
    int         kinds[6];
    logic [5:0] r;
    Reset    = 1'b1;
    Opcode   = 6'd0;
    Zero     = 1'b0;
    MemReady = 1'b0;

    do_reset(2, 1'b0, 0);

    // Instruction mix, zero wait.
    kinds = '{K_LW, K_SW, K_R, K_ADDI, K_BEQ, K_J};
    foreach (kinds[i]) do_instr(kinds[i], 0, 0, 6'h3F);

    // Reset during EXEC of an R-type.
    cyc(F, 1'b1, 1'b0, 1'b0, 6'b000000);
    cyc(D, 1'b0, 1'b0, 1'b0, 6'b000000);
    do_reset(3, 1'b1, EX);

    // Memory waits, illegal opcode, timeouts and the timeout boundary.
    do_instr(K_LW, 2, 3, 6'h3F);
    do_instr(K_ILL, 0, 0, 6'b111111);
    do_instr(K_SW, 0, 20, 6'h3F);
    do_instr(K_SW, 0, 3, 6'h3F);
    do_instr(K_LW, 0, 7, 6'h3F);
    do_instr(K_LW, 3, 3, 6'h3F);
    do_instr(K_R, 9, 0, 6'h3F);
    do_instr(K_BEQ, 0, 0, 6'h3F);

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      do r = 6'($urandom); while (is_legal(r));
      do_instr($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 5), r);
    end

    repeat (3) @(negedge Clock);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
